// File: rtl/div16_seq.sv
// rtl/div16_seq.sv - sequential 16-bit unsigned restoring divider, one quotient bit per cycle
// Optional build macro: DIV16_ZERO_SHORTCUT_EN (zero divisor goes straight IDLE -> DONE)
module div16_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor_n,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [16:0] r;
  logic [15:0] q;
  logic [15:0] d;
  logic [3:0]  count;
  logic        zero_flag;

  logic [16:0] s;
  logic [16:0] t;
  logic        ge;
  logic [16:0] r_nxt;
  logic [15:0] q_nxt;
  logic        start_zero;

  assign start_zero = (divisor_n == 16'hFFFF);

  // Trial subtraction S - D formed as S + ~D + 1, the way the upstream inverter feeds it
  always_comb begin
    s     = {r[15:0], q[15]};
    t     = s + {1'b1, ~d} + 17'd1;
    ge    = (s >= {1'b0, d});
    r_nxt = ge ? t : s;
    q_nxt = {q[14:0], ge};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; a start is only honoured from IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef DIV16_ZERO_SHORTCUT_EN
          state_nxt = start_zero ? DONE : RUN;
`else
          state_nxt = RUN;
`endif
        end
      end
      RUN:     if (count == 4'd15) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decode straight from the state register, so no input reaches them combinationally
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath: operand capture, iteration, and result registers loaded only on the way into DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r         <= '0;
      q         <= '0;
      d         <= '0;
      count     <= '0;
      zero_flag <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            d         <= ~divisor_n;
            q         <= dividend;
            r         <= '0;
            count     <= '0;
            zero_flag <= start_zero;
`ifdef DIV16_ZERO_SHORTCUT_EN
            if (start_zero) begin
              quotient  <= 16'hFFFF;
              remainder <= dividend;
              div_zero  <= 1'b1;
            end
`endif
          end
        end
        RUN: begin
          r     <= r_nxt;
          q     <= q_nxt;
          count <= count + 4'd1;
          if (count == 4'd15) begin
            quotient  <= q_nxt;
            remainder <= r_nxt[15:0];
            div_zero  <= zero_flag;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div16_seq.sv
// tb/tb_div16_seq.sv - directed self-checking bench for div16_seq
module tb_div16_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor_n;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_zero;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] last_q = 16'h0;
  logic [15:0] last_r = 16'h0;

`ifdef DIV16_ZERO_SHORTCUT_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 17;
`endif

  div16_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor_n (divisor_n),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present start across one rising edge (edge N), then scramble the operand pins
  task automatic do_start(input logic [15:0] dvd, input logic [15:0] dn);
    @(negedge clk);
    start     = 1'b1;
    dividend  = dvd;
    divisor_n = dn;
    @(posedge clk);
    #1;
    start     = 1'b0;
    dividend  = 16'hA5A5;
    divisor_n = 16'h5A5A;
  endtask

  // Run one division; optionally inject a start mid-run and/or during DONE
  task automatic run_div(input string tag, input logic [15:0] dvd, input logic [15:0] dn,
                         input logic [15:0] eq, input logic [15:0] er, input logic ez,
                         input int elat, input int inj, input bit poke_done);
    int lat;
    int nbusy;
    int overlap;
    lat = 0; nbusy = 0; overlap = 0;
    do_start(dvd, dn);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (inj != 0 && i == inj) begin
        start = 1'b1; dividend = 16'd9; divisor_n = 16'hFFFC;
      end
      if (inj != 0 && i == inj + 1) begin
        start = 1'b0; dividend = 16'h0; divisor_n = 16'h0;
      end
      if (busy) nbusy++;
      if (busy && done) overlap++;
      if (i == 10 && !done) check({tag, " held_q"}, quotient, last_q);
      if (i == 10 && !done) check({tag, " held_r"}, remainder, last_r);
      if (done) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " busy_cycles"}, nbusy, (elat == 17) ? 16 : 0);
    check({tag, " busy_done_overlap"}, overlap, 0);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_zero"}, div_zero, ez);
    last_q = eq;
    last_r = er;
    if (poke_done) begin
      start = 1'b1; dividend = 16'd7; divisor_n = 16'hFFFE;
      @(negedge clk);
      start = 1'b0;
      check({tag, " start_in_done_busy"}, busy, 1'b0);
      check({tag, " start_in_done_done"}, done, 1'b0);
      check({tag, " start_in_done_q"}, quotient, eq);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = 16'h0; divisor_n = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset quotient", quotient, 16'h0);
    check("reset remainder", remainder, 16'h0);
    check("reset div_zero", div_zero, 1'b0);
    rst = 1'b0;

    run_div("100/7", 16'd100, 16'hFFF8, 16'd14, 16'd2, 1'b0, 17, 0, 1'b0);
    run_div("ffff/1", 16'hFFFF, 16'hFFFE, 16'hFFFF, 16'd0, 1'b0, 17, 0, 1'b0);
    run_div("5/9", 16'd5, 16'hFFF6, 16'd0, 16'd5, 1'b0, 17, 0, 1'b1);
    run_div("1234/0", 16'h1234, 16'hFFFF, 16'hFFFF, 16'h1234, 1'b1, ZERO_LAT, 0, 1'b0);
    run_div("50/5 inj", 16'd50, 16'hFFFA, 16'd10, 16'd0, 1'b0, 17, 5, 1'b0);

    do_start(16'd300, 16'hFFF8);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst quotient", quotient, 16'h0);
    check("midrst remainder", remainder, 16'h0);
    check("midrst div_zero", div_zero, 1'b0);
    last_q = 16'h0;
    last_r = 16'h0;

    run_div("1000/10", 16'd1000, 16'hFFF5, 16'd100, 16'd0, 1'b0, 17, 0, 1'b0);
    run_div("b2b 65535/256", 16'd65535, 16'hFEFF, 16'd255, 16'd255, 1'b0, 17, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
